// File: rtl/ram_seq_master.sv
// ram_seq_master: write/read-back self-test engine on the client side of the
// SRAM controller. It writes seed+i to base_addr+i for i in [0, count), reads
// every word back, and stops at the first mismatch or handshake timeout.
//
// Handshake: a request is a level on we or re (never both). The request holds
// until the synchronized done rises, then drops. No new request is raised
// until synchronized done is low again and GAP idle cycles have passed.
module ram_seq_master #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int GAP     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              finish,
  output logic              pass,
  output logic              timeout,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic              en,
  output logic              we,
  output logic              re,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] wr_data,
  input  logic              ctrl_done,
  input  logic [DATA_W-1:0] ctrl_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE, W_REQ, W_WAIT, W_GAP, R_REQ, R_WAIT, R_GAP, DONE
  } state_t;

  localparam logic [15:0] TO_C  = 16'(TIMEOUT);
  localparam logic [7:0]  GAP_C = 8'(GAP);

  state_t state, state_next;

  logic              done_s1, done_sync, done_prev;
  logic              done_rise;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] base_r, count_r;
  logic [DATA_W-1:0] seed_r;
  logic [15:0]       tcnt;
  logic [7:0]        gcnt;
  logic              err_flag;
  logic              gap_done;
  logic              last;
  logic              timed_out;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_pat;

  assign dbg_state = state;
  assign done_rise = done_sync & ~done_prev;
  assign gap_done  = ~done_sync && (gcnt == GAP_C);
  assign last      = (i == count_r - 1'b1);
  assign timed_out = (tcnt == TO_C);
  assign cur_addr  = base_r + i;
  assign cur_pat   = seed_r + DATA_W'(i);

  // Two-flop synchronizer for the asynchronous controller done, plus edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_s1   <= 1'b0;
      done_sync <= 1'b0;
      done_prev <= 1'b0;
    end else begin
      done_s1   <= ctrl_done;
      done_sync <= done_s1;
      done_prev <= done_sync;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; REQ states hold off while a previous done is still high.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = (count == '0) ? DONE : W_REQ;
      W_REQ:  if (!done_sync) state_next = W_WAIT;
      W_WAIT: if (done_rise) state_next = W_GAP;
              else if (timed_out) state_next = DONE;
      W_GAP:  if (gap_done) state_next = last ? R_REQ : W_REQ;
      R_REQ:  if (!done_sync) state_next = R_WAIT;
      R_WAIT: if (done_rise) state_next = R_GAP;
              else if (timed_out) state_next = DONE;
      R_GAP:  if (gap_done) state_next = (err_flag || last) ? DONE : R_REQ;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs, driven by the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; finish <= 1'b0; pass <= 1'b0; timeout <= 1'b0;
      err_addr <= '0; err_data <= '0; err_flag <= 1'b0;
      en <= 1'b0; we <= 1'b0; re <= 1'b0;
      addr_out <= '0; wr_data <= '0;
      i <= '0; base_r <= '0; count_r <= '0; seed_r <= '0;
      tcnt <= '0; gcnt <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_r   <= base_addr;
            count_r  <= count;
            seed_r   <= seed;
            busy     <= 1'b1;
            pass     <= (count == '0);
            timeout  <= 1'b0;
            err_addr <= '0;
            err_data <= '0;
            err_flag <= 1'b0;
            i        <= '0;
            en       <= (count != '0);
          end
        end
        W_REQ, R_REQ: begin
          if (!done_sync) begin
            addr_out <= cur_addr;
            if (state == W_REQ) begin
              wr_data <= cur_pat;
              we      <= 1'b1;
            end else begin
              re      <= 1'b1;
            end
            tcnt <= '0;
          end
        end
        W_WAIT, R_WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (done_rise) begin
            we   <= 1'b0;
            re   <= 1'b0;
            gcnt <= '0;
            if (state == R_WAIT && ctrl_data != cur_pat && !err_flag) begin
              err_flag <= 1'b1;
              err_addr <= cur_addr;
              err_data <= ctrl_data;
              pass     <= 1'b0;
            end
          end else if (timed_out) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            we      <= 1'b0;
            re      <= 1'b0;
          end
        end
        W_GAP, R_GAP: begin
          if (done_sync) gcnt <= '0;
          else if (!gap_done) gcnt <= gcnt + 1'b1;
          if (gap_done) begin
            if (last) begin
              i <= '0;
              if (state == R_GAP && !err_flag) pass <= 1'b1;
            end else begin
              i <= i + 1'b1;
            end
          end
        end
        DONE: begin
          en     <= 1'b0;
          busy   <= 1'b0;
          finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_seq_master.sv
// Directed bench for ram_seq_master with a behavioural SRAM controller responder.
module tb_ram_seq_master;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr, count;
  logic [DW-1:0] seed;
  logic          busy, finish, pass, timeout;
  logic [AW-1:0] err_addr, addr_out;
  logic [DW-1:0] err_data, wr_data;
  logic          en, we, re;
  logic          ctrl_done;
  logic [DW-1:0] ctrl_data;
  logic [2:0]    dbg_state;

  ram_seq_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(20), .GAP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .seed(seed), .busy(busy), .finish(finish), .pass(pass), .timeout(timeout),
    .err_addr(err_addr), .err_data(err_data), .en(en), .we(we), .re(re),
    .addr_out(addr_out), .wr_data(wr_data), .ctrl_done(ctrl_done),
    .ctrl_data(ctrl_data), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Responder state and logs
  logic [DW-1:0] mem [0:1023];
  logic [AW-1:0] wr_a_q[$];
  logic [DW-1:0] wr_d_q[$];
  logic [AW-1:0] rd_a_q[$];
  int            rstate = 0;
  int            dly = 0;
  int            wr_cnt = 0;
  int            drop_n = 0;
  bit            corrupt_en = 0;
  logic [AW-1:0] corrupt_addr = '0;
  bit            rd_kind = 0;
  logic [AW-1:0] req_a = '0;
  logic [DW-1:0] req_d = '0;

  // Handshake-rule monitors
  int            overlap_err = 0;
  int            stab_err = 0;
  bit            req_seen = 0;
  bit            we_prev = 0;
  logic [AW-1:0] held_a = '0;
  logic [DW-1:0] held_d = '0;

  always @(negedge clk) begin
    if (we && re) overlap_err++;
    if (en || we || re) req_seen = 1;
    if (we) begin
      if (we_prev && (addr_out !== held_a || wr_data !== held_d)) stab_err++;
      held_a = addr_out;
      held_d = wr_data;
    end
    we_prev = we;
  end

  // Controller model: done rises ~6 cycles after a request, stays high 4 cycles.
  initial begin
    ctrl_done = 1'b0;
    ctrl_data = '0;
    for (int k = 0; k < 1024; k++) mem[k] = '0;
    forever begin
      @(negedge clk);
      case (rstate)
        0: begin
          if (we && !ctrl_done) begin
            wr_a_q.push_back(addr_out);
            wr_d_q.push_back(wr_data);
            rd_kind = 0; req_a = addr_out; req_d = wr_data;
            wr_cnt++;
            if (drop_n != 0 && wr_cnt == drop_n) rstate = 3;
            else begin dly = 6; rstate = 1; end
          end else if (re && !ctrl_done) begin
            rd_a_q.push_back(addr_out);
            rd_kind = 1; req_a = addr_out;
            dly = 6; rstate = 1;
          end
        end
        1: begin
          dly--;
          if (dly == 0) begin
            if (!rd_kind) begin
              mem[req_a[9:0]] = req_d;
              ctrl_data = '0;
            end else if (corrupt_en && req_a == corrupt_addr) begin
              ctrl_data = 16'hFFFF;
            end else begin
              ctrl_data = mem[req_a[9:0]];
            end
            ctrl_done = 1'b1;
            dly = 4; rstate = 2;
          end
        end
        2: begin
          dly--;
          if (dly == 0) begin ctrl_done = 1'b0; rstate = 4; end
        end
        default: if (!we && !re) rstate = 0;
      endcase
    end
  end

  task automatic clear_logs();
    wr_a_q.delete(); wr_d_q.delete(); rd_a_q.delete();
    wr_cnt = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW-1:0] c,
                             input logic [DW-1:0] s);
    base_addr = a; count = c; seed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input int max_cyc, output bit got);
    got = 0;
    for (int k = 0; k < max_cyc && !got; k++) begin
      @(negedge clk);
      if (finish) got = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; seed = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, finish, pass, timeout} !== 4'b0000)
      $display("FAIL reset_status: got %b want 0000", {busy, finish, pass, timeout}); else passes++;
    checks++; if ({en, we, re} !== 3'b000)
      $display("FAIL reset_req: got %b want 000", {en, we, re}); else passes++;
    checks++; if ({addr_out, wr_data, err_addr, err_data} !== 68'h0)
      $display("FAIL reset_data: got %h want 0", {addr_out, wr_data, err_addr, err_data}); else passes++;
    checks++; if (dbg_state !== 3'd0)
      $display("FAIL reset_state: got %0d want 0", dbg_state); else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit got;
    clear_logs();
    pulse_start(18'h00010, 18'd4, 16'hA5A0);
    wait_finish(1000, got);
    checks++; if (!got) $display("FAIL basic_finish: got none want pulse"); else passes++;
    checks++; if ({pass, timeout} !== 2'b10)
      $display("FAIL basic_pass_to: got %b want 10", {pass, timeout}); else passes++;
    checks++; if (err_addr !== 18'h0) $display("FAIL basic_err_addr: got %h want 0", err_addr); else passes++;
    checks++; if (wr_a_q.size() != 4 || rd_a_q.size() != 4)
      $display("FAIL basic_counts: got %0d/%0d want 4/4", wr_a_q.size(), rd_a_q.size()); else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++; if (wr_a_q[k] !== 18'h10 + 18'(k) || wr_d_q[k] !== 16'hA5A0 + 16'(k))
        $display("FAIL basic_write%0d: got %h/%h want %h/%h", k, wr_a_q[k], wr_d_q[k],
                 18'h10 + 18'(k), 16'hA5A0 + 16'(k)); else passes++;
      checks++; if (rd_a_q[k] !== 18'h10 + 18'(k))
        $display("FAIL basic_read%0d: got %h want %h", k, rd_a_q[k], 18'h10 + 18'(k)); else passes++;
    end
  endtask

  task automatic test_mismatch();
    bit got;
    clear_logs();
    corrupt_en = 1; corrupt_addr = 18'h12;
    pulse_start(18'h00010, 18'd4, 16'hA5A0);
    wait_finish(1000, got);
    corrupt_en = 0;
    checks++; if (!got) $display("FAIL mis_finish: got none want pulse"); else passes++;
    checks++; if (pass !== 1'b0) $display("FAIL mis_pass: got %b want 0", pass); else passes++;
    checks++; if (err_addr !== 18'h12) $display("FAIL mis_err_addr: got %h want 00012", err_addr); else passes++;
    checks++; if (err_data !== 16'hFFFF) $display("FAIL mis_err_data: got %h want ffff", err_data); else passes++;
    checks++; if (rd_a_q.size() != 3) $display("FAIL mis_reads: got %0d want 3", rd_a_q.size()); else passes++;
  endtask

  task automatic test_wrap();
    bit got;
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    ea = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    ed = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    clear_logs();
    pulse_start(18'h3FFFE, 18'd4, 16'hFFFE);
    wait_finish(1000, got);
    checks++; if (!got || pass !== 1'b1)
      $display("FAIL wrap_pass: got finish=%0d pass=%b want 1/1", got, pass); else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++; if (wr_a_q[k] !== ea[k] || wr_d_q[k] !== ed[k] || rd_a_q[k] !== ea[k])
        $display("FAIL wrap_word%0d: got %h/%h/%h want %h/%h", k, wr_a_q[k], wr_d_q[k],
                 rd_a_q[k], ea[k], ed[k]); else passes++;
    end
  endtask

  task automatic test_timeout();
    bit got;
    clear_logs();
    drop_n = 2;
    pulse_start(18'h00080, 18'd4, 16'h1000);
    wait_finish(1000, got);
    drop_n = 0;
    checks++; if (!got) $display("FAIL to_finish: got none want pulse"); else passes++;
    checks++; if ({timeout, pass, we} !== 3'b100)
      $display("FAIL to_flags: got %b want 100", {timeout, pass, we}); else passes++;
    checks++; if (wr_a_q.size() != 2 || rd_a_q.size() != 0)
      $display("FAIL to_reqs: got %0d/%0d want 2/0", wr_a_q.size(), rd_a_q.size()); else passes++;
    repeat (3) @(negedge clk);
    clear_logs();
    pulse_start(18'h00080, 18'd2, 16'h1000);
    checks++; if (timeout !== 1'b0) $display("FAIL to_clear: got %b want 0", timeout); else passes++;
    wait_finish(1000, got);
    checks++; if (!got || pass !== 1'b1 || timeout !== 1'b0)
      $display("FAIL to_rerun: got %0d/%b/%b want 1/1/0", got, pass, timeout); else passes++;
  endtask

  task automatic test_count_zero();
    repeat (2) @(negedge clk);
    req_seen = 0;
    pulse_start(18'h00100, 18'd0, 16'h0);
    checks++; if ({busy, finish} !== 2'b10)
      $display("FAIL zero_busy: got %b want 10", {busy, finish}); else passes++;
    @(negedge clk);
    checks++; if ({busy, finish, pass} !== 3'b011)
      $display("FAIL zero_finish: got %b want 011", {busy, finish, pass}); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (req_seen !== 1'b0) $display("FAIL zero_noreq: got %b want 0", req_seen); else passes++;
  endtask

  task automatic test_ignore_start();
    bit got;
    clear_logs();
    pulse_start(18'h00020, 18'd3, 16'h1234);
    repeat (10) @(negedge clk);
    pulse_start(18'h00100, 18'd5, 16'h0000);
    wait_finish(1000, got);
    checks++; if (!got || pass !== 1'b1)
      $display("FAIL ign_pass: got %0d/%b want 1/1", got, pass); else passes++;
    checks++; if (wr_a_q.size() != 3 || wr_a_q[2] !== 18'h22 || wr_d_q[2] !== 16'h1236)
      $display("FAIL ign_run: got n=%0d %h/%h want 3 00022/1236", wr_a_q.size(), wr_a_q[2],
               wr_d_q[2]); else passes++;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL ign_idle: got %b want 0", busy); else passes++;
  endtask

  task automatic test_reset_midrun();
    bit got;
    bit seen_re;
    clear_logs();
    pulse_start(18'h00040, 18'd2, 16'h0500);
    seen_re = 0;
    for (int k = 0; k < 600 && !seen_re; k++) begin
      @(negedge clk);
      if (re) seen_re = 1;
    end
    checks++; if (!seen_re) $display("FAIL mid_reach_read: got none want re"); else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({en, we, re, busy, finish, pass, timeout} !== 7'b0)
      $display("FAIL mid_reset_ctl: got %b want 0", {en, we, re, busy, finish, pass, timeout}); else passes++;
    checks++; if ({addr_out, wr_data, err_addr, err_data} !== 68'h0)
      $display("FAIL mid_reset_data: got %h want 0", {addr_out, wr_data, err_addr, err_data}); else passes++;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    clear_logs();
    pulse_start(18'h00040, 18'd2, 16'h0500);
    wait_finish(1000, got);
    checks++; if (!got || pass !== 1'b1 || rd_a_q.size() != 2)
      $display("FAIL mid_rerun: got %0d/%b/%0d want 1/1/2", got, pass, rd_a_q.size()); else passes++;
  endtask

  task automatic test_handshake_rules();
    checks++; if (overlap_err != 0) $display("FAIL we_re_overlap: got %0d want 0", overlap_err); else passes++;
    checks++; if (stab_err != 0) $display("FAIL write_stable: got %0d want 0", stab_err); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_wrap();
    test_timeout();
    test_count_zero();
    test_ignore_start();
    test_reset_midrun();
    test_handshake_rules();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
